wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/wb_arb_pkg.sv | 13 +
 rtl/wb_timeout_counter.sv | 37 +++
 rtl/wb_master_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_master_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: FSM encodings and
// stall counter width.
package wb_arb_pkg;

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBusM0 = 2'd1;
  localparam logic [1:0] StBusM1 = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

endpackage

// File: rtl/wb_timeout_counter.sv
// Stall cycle counter. expired_o fires in the cycle whose stall would bring the
// count up to limit_i; a zero limit never expires.
module wb_timeout_counter
  import wb_arb_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [CntW-1:0] limit_i,
  output logic            expired_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Clear has priority; saturate so a disabled timeout cannot wrap around.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (limit_i != '0) && (cnt_q == (limit_i - CntOne));

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-transfer stall timeout.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_cyc,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  output logic [1:0]  grant,
  output logic        timeout_irq,
  input  logic        irq_clr
);

  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

  logic [1:0] state_q, state_d;
  logic       last_q, last_d;   // index of the most recently granted master
  logic [1:0] err_q, err_d;
  logic       irq_q, irq_d;

  logic bus_m0, bus_m1, in_bus, own_cyc, own_stb;
  logic stall_en, leave, expired;

  assign bus_m0   = (state_q == StBusM0);
  assign bus_m1   = (state_q == StBusM1);
  assign in_bus   = bus_m0 | bus_m1;
  assign own_cyc  = bus_m0 ? m0_cyc : (bus_m1 ? m1_cyc : 1'b0);
  assign own_stb  = bus_m0 ? m0_stb : (bus_m1 ? m1_stb : 1'b0);
  assign stall_en = in_bus & own_stb & ~s_ack;
  assign leave    = in_bus & ~own_cyc;

  wb_timeout_counter u_timeout (
    .clk_i     (wb_clk),
    .rst_ni    (wb_rst_n),
    .en_i      (stall_en),
    .clr_i     (~stall_en | leave | expired),
    .limit_i   (Limit),
    .expired_o (expired)
  );

  // Arbitration and ownership FSM; err_d is a one-cycle pulse on entry to StErr.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    err_d   = 2'b00;
    case (state_q)
      StIdle: begin
        if (m0_cyc && (!m1_cyc || last_q)) begin
          state_d = StBusM0;
          last_d  = 1'b0;
        end else if (m1_cyc) begin
          state_d = StBusM1;
          last_d  = 1'b1;
        end
      end
      StBusM0: begin
        if (expired) begin
          state_d = StErr;
          err_d   = 2'b01;
        end else if (!m0_cyc) begin
          state_d = StIdle;
        end
      end
      StBusM1: begin
        if (expired) begin
          state_d = StErr;
          err_d   = 2'b10;
        end else if (!m1_cyc) begin
          state_d = StIdle;
        end
      end
      StErr: begin
        // last_q still names the master that timed out.
        if (last_q ? !m1_cyc : !m0_cyc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Sticky irq: a new timeout beats a simultaneous clear.
  always_comb begin
    irq_d = expired | (irq_q & ~irq_clr);
  end

  // State registers.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      err_q   <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  // Bus steering: the owner is wired straight through, everything else is zero.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_o  = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (bus_m0) begin
      s_cyc    = m0_cyc;
      s_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_dat_o  = m0_dat_i;
      m0_ack   = s_ack;
      m0_dat_o = s_dat_i;
    end else if (bus_m1) begin
      s_cyc    = m1_cyc;
      s_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_o  = m1_dat_i;
      m1_ack   = s_ack;
      m1_dat_o = s_dat_i;
    end
  end

  assign grant       = {bus_m1, bus_m0};
  assign m0_err      = err_q[0];
  assign m1_err      = err_q[1];
  assign timeout_irq = irq_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed and random bench for wb_master_arbiter against a transaction-level
// ownership model.
module tb_wb_master_arbiter;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mcyc = '0, mstb = '0, mwe = '0;
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [31:0] s_dat_i = '0;
  logic        s_ack = 1'b0, irq_clr = 1'b0;

  logic [31:0] m0_dat_o, m1_dat_o, s_adr, s_dat_o;
  logic        m0_ack, m1_ack, m0_err, m1_err, s_cyc, s_stb, s_we, timeout_irq;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  // Model: owner of the bus (-1 none), whether it is parked in error, etc.
  int owner, last, stall, epulse;
  bit in_err, irq;

  always #5 clk = ~clk;

  wb_master_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .wb_clk(clk), .wb_rst_n(rst_n),
    .m0_cyc(mcyc[0]), .m0_stb(mstb[0]), .m0_we(mwe[0]), .m0_adr(madr[0]),
    .m0_dat_i(mdat[0]), .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(mcyc[1]), .m1_stb(mstb[1]), .m1_we(mwe[1]), .m1_adr(madr[1]),
    .m1_dat_i(mdat[1]), .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .grant(grant), .timeout_irq(timeout_irq),
    .irq_clr(irq_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; in_err = 0; last = 1; stall = 0; epulse = -1; irq = 0;
  endtask

  // Let inputs settle, then compare every output with the model.
  task automatic settle_check();
    bit bus;
    logic [1:0] own;
    #1;
    bus = (owner >= 0) && !in_err;
    own = (owner == 1) ? 2'b10 : 2'b01;
    check("grant", {30'd0, grant}, bus ? {30'd0, own} : 32'd0);
    check("s_ctl", {29'd0, s_cyc, s_stb, s_we},
          bus ? {29'd0, mcyc[owner], mstb[owner], mwe[owner]} : 32'd0);
    check("s_adr", s_adr, bus ? madr[owner] : 32'd0);
    check("s_dat_o", s_dat_o, bus ? mdat[owner] : 32'd0);
    check("acks", {30'd0, m1_ack, m0_ack}, (bus && s_ack) ? {30'd0, own} : 32'd0);
    check("m0_dat_o", m0_dat_o, (bus && owner == 0) ? s_dat_i : 32'd0);
    check("m1_dat_o", m1_dat_o, (bus && owner == 1) ? s_dat_i : 32'd0);
    check("errs", {30'd0, m1_err, m0_err},
          (epulse == 0) ? 32'd1 : ((epulse == 1) ? 32'd2 : 32'd0));
    check("irq", {31'd0, timeout_irq}, {31'd0, irq});
  endtask

  // Apply the rules of one clock edge to the model.
  task automatic model_update();
    bit bus, stalled, set;
    bus = (owner >= 0) && !in_err;
    set = 0;
    epulse = -1;
    if (bus) begin
      stalled = mstb[owner] && !s_ack;
      if (stalled && stall + 1 == T) begin
        in_err = 1; epulse = owner; set = 1; stall = 0;
      end else begin
        stall = (stalled && mcyc[owner]) ? stall + 1 : 0;
        if (!mcyc[owner]) owner = -1;
      end
    end else if (in_err) begin
      if (!mcyc[owner]) begin
        in_err = 0; owner = -1;
      end
    end else begin
      stall = 0;
      if (mcyc[0] && mcyc[1]) owner = 1 - last;
      else if (mcyc[0]) owner = 0;
      else if (mcyc[1]) owner = 1;
      if (owner >= 0) last = owner;
    end
    irq = set ? 1'b1 : (irq_clr ? 1'b0 : irq);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic idle_inputs();
    mcyc = '0; mstb = '0; mwe = '0; s_ack = 0; irq_clr = 0;
  endtask

  // Reset asserted between edges; outputs must drop before any clock edge.
  task automatic apply_reset();
    rst_n = 0;
    model_reset();
    settle_check();
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
  endtask

  initial begin
    madr[0] = 32'h1000_0000; madr[1] = 32'h2000_0000;
    mdat[0] = 32'hA5A5_0000; mdat[1] = 32'h5A5A_1111;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    step();

    // Single master, slave acks at cycle 3.
    mcyc = 2'b01; mstb = 2'b01; mwe = 2'b01; s_dat_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      s_ack = (i == 3);
      if (i == 4) mcyc = 2'b00;
      settle_check();
      if (i == 0) check("d34_g0", {30'd0, grant}, 32'd0);
      if (i == 1) check("d34_g1", {30'd0, grant}, 32'd1);
      if (i == 3) check("d34_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
      if (i == 2) check("d34_noack", {30'd0, m1_ack, m0_ack}, 32'd0);
      advance();
    end
    idle_inputs();

    // Tie from reset: m0 first, idle turnaround, then m1 holds 4 beats.
    apply_reset();
    mcyc = 2'b11; mstb = 2'b11;
    settle_check(); advance();
    settle_check(); check("d35_m0", {30'd0, grant}, 32'd1); advance();
    s_ack = 1; step(); s_ack = 0;
    mcyc = 2'b10; step();
    settle_check(); check("d35_idle", {30'd0, grant}, 32'd0); advance();
    mcyc = 2'b11;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1; s_dat_i = 32'h100 + i;
      settle_check();
      check("d36_hold", {30'd0, grant}, 32'd2);
      check("d36_ack", {30'd0, m1_ack, m0_ack}, 32'd2);
      advance();
    end
    s_ack = 0; mcyc = 2'b01; step();
    step();
    settle_check(); check("d36_m0", {30'd0, grant}, 32'd1); advance();
    idle_inputs();

    // Timeout: eight stall cycles then error, sticky irq until cleared.
    apply_reset();
    mcyc = 2'b01; mstb = 2'b01;
    for (int i = 0; i < 11; i++) begin
      settle_check();
      if (i == 9) begin
        check("d37_err", {30'd0, m1_err, m0_err}, 32'd1);
        check("d37_scyc", {31'd0, s_cyc}, 32'd0);
      end
      if (i == 10) check("d37_once", {30'd0, m1_err, m0_err}, 32'd0);
      advance();
    end
    mcyc = 2'b00; mstb = 2'b00;
    step(); step();
    settle_check(); check("d37_sticky", {31'd0, timeout_irq}, 32'd1); advance();
    irq_clr = 1; step(); irq_clr = 0;
    settle_check(); check("d37_clr", {31'd0, timeout_irq}, 32'd0); advance();

    // Ack on the eighth stall cycle wins over the timeout.
    apply_reset();
    mcyc = 2'b01; mstb = 2'b01;
    for (int i = 0; i < 11; i++) begin
      s_ack = (i == 8);
      settle_check();
      if (i == 8) check("d38_ack", {30'd0, m1_ack, m0_ack}, 32'd1);
      if (i == 9) check("d38_noerr", {30'd0, m1_err, m0_err}, 32'd0);
      advance();
    end
    check("d38_irq", {31'd0, timeout_irq}, 32'd0);
    idle_inputs();
    step();

    // Reset in the middle of a burst.
    mcyc = 2'b10; mstb = 2'b10; s_ack = 1;
    step(); step(); step();
    apply_reset();
    step();

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      for (int m = 0; m < 2; m++) begin
        if (mcyc[m]) mcyc[m] = ($urandom_range(0, 5) != 0);
        else mcyc[m] = ($urandom_range(0, 2) == 0);
        mstb[m] = ($urandom_range(0, 3) != 0);
        mwe[m]  = 1'($urandom);
        madr[m] = $urandom;
        mdat[m] = $urandom;
      end
      s_ack   = ($urandom_range(0, 4) == 0);
      s_dat_i = $urandom;
      irq_clr = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
